// File: rtl/maple_sched_pkg.sv
// rtl/maple_sched_pkg.sv - shared state encoding, marker byte and width helper for the scheduler
package maple_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RECV     = 3'd3,
    ST_TOUT     = 3'd4,
    ST_GAP      = 3'd5
  } sched_state_e;

  localparam logic [7:0] TIMEOUT_MARKER = 8'hFF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/maple_txn_scheduler_if.sv
// rtl/maple_txn_scheduler_if.sv - requester, transceiver and response streams of the scheduler
interface maple_txn_scheduler_if
  import maple_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_tvalid;
  logic [NUM_REQ-1:0]   req_tready;
  logic [NUM_REQ*8-1:0] req_tdata;
  logic [NUM_REQ-1:0]   req_tlast;

  logic       m_axis_tx_tvalid;
  logic       m_axis_tx_tready;
  logic [7:0] m_axis_tx_tdata;
  logic       m_axis_tx_tlast;

  logic       s_axis_rx_tvalid;
  logic       s_axis_rx_tready;
  logic [7:0] s_axis_rx_tdata;
  logic       s_axis_rx_tlast;

  logic           rsp_tvalid;
  logic           rsp_tready;
  logic [7:0]     rsp_tdata;
  logic           rsp_tlast;
  logic [IDW-1:0] rsp_tdest;
  logic           rsp_tuser;

  modport master (
    input  req_tvalid, req_tdata, req_tlast,
    output req_tready,
    output m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast,
    input  m_axis_tx_tready,
    input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tlast,
    output s_axis_rx_tready,
    output rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tdest, rsp_tuser,
    input  rsp_tready
  );

  modport slave (
    output req_tvalid, req_tdata, req_tlast,
    input  req_tready,
    input  m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast,
    output m_axis_tx_tready,
    output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tlast,
    input  s_axis_rx_tready,
    input  rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tdest, rsp_tuser,
    output rsp_tready
  );

endinterface

// File: rtl/maple_rr_arbiter.sv
// rtl/maple_rr_arbiter.sv - combinational round-robin pick starting just above last_grant
module maple_rr_arbiter
  import maple_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id
);

  int             idx;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

endmodule

// File: rtl/maple_txn_scheduler.sv
// rtl/maple_txn_scheduler.sv - shares one Maple Bus transceiver among NUM_REQ requesters
module maple_txn_scheduler
  import maple_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  maple_txn_scheduler_if.master bus,
  output logic                  busy,
  output logic [15:0]           timeout_count
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_SEND     = ST_SEND;
  localparam logic [2:0] S_WAIT_RSP = ST_WAIT_RSP;
  localparam logic [2:0] S_RECV     = ST_RECV;
  localparam logic [2:0] S_TOUT     = ST_TOUT;
  localparam logic [2:0] S_GAP      = ST_GAP;

  logic [2:0]     state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last_grant;
  logic [31:0]    timer;
  logic [31:0]    gap_cnt;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           sel_valid, sel_last, tx_hs, rx_hs, rx_phase;

  maple_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req         (bus.req_tvalid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_valid = bus.req_tvalid[grant];
  assign sel_last  = bus.req_tlast[grant];
  assign rx_phase  = (state == S_WAIT_RSP) || (state == S_RECV);
  assign tx_hs     = (state == S_SEND) && sel_valid && bus.m_axis_tx_tready;
  assign rx_hs     = rx_phase && bus.s_axis_rx_tvalid && bus.rsp_tready;
  assign busy      = (state != S_IDLE);

  // Every stream output is a pure function of state, so reset and GAP idle them for free.
  always_comb begin
    bus.req_tready       = '0;
    bus.m_axis_tx_tvalid = 1'b0;
    bus.m_axis_tx_tdata  = 8'h00;
    bus.m_axis_tx_tlast  = 1'b0;
    bus.s_axis_rx_tready = 1'b0;
    bus.rsp_tvalid       = 1'b0;
    bus.rsp_tdata        = 8'h00;
    bus.rsp_tlast        = 1'b0;
    bus.rsp_tuser        = 1'b0;
    bus.rsp_tdest        = (state == S_IDLE) ? '0 : grant;
    case (state)
      S_SEND: begin
        bus.m_axis_tx_tvalid  = sel_valid;
        bus.m_axis_tx_tdata   = bus.req_tdata[{grant, 3'b000} +: 8];
        bus.m_axis_tx_tlast   = sel_last;
        bus.req_tready[grant] = bus.m_axis_tx_tready;
      end
      S_WAIT_RSP, S_RECV: begin
        bus.s_axis_rx_tready = bus.rsp_tready;
        bus.rsp_tvalid       = bus.s_axis_rx_tvalid;
        bus.rsp_tdata        = bus.s_axis_rx_tdata;
        bus.rsp_tlast        = bus.s_axis_rx_tlast;
      end
      S_TOUT: begin
        bus.rsp_tvalid = 1'b1;
        bus.rsp_tdata  = TIMEOUT_MARKER;
        bus.rsp_tlast  = 1'b1;
        bus.rsp_tuser  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      grant         <= '0;
      last_grant    <= IDW'(NUM_REQ - 1);
      timer         <= '0;
      gap_cnt       <= '0;
      timeout_count <= '0;
    end else begin
      if (state != S_GAP) gap_cnt <= '0;
      case (state)
        S_IDLE: if (grant_valid) begin
          grant      <= grant_id;
          last_grant <= grant_id;
          state      <= S_SEND;
        end
        S_SEND: if (tx_hs && sel_last) begin
          timer <= '0;
          state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          timer <= timer + 32'd1;
          // A beat already offered on the terminal cycle beats the timeout.
          if (rx_hs) state <= bus.s_axis_rx_tlast ? S_GAP : S_RECV;
          else if (!bus.s_axis_rx_tvalid && timer >= 32'(TIMEOUT_CYCLES - 1)) state <= S_TOUT;
        end
        S_RECV: if (rx_hs && bus.s_axis_rx_tlast) state <= S_GAP;
        S_TOUT: if (bus.rsp_tready) begin
          if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          state <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == 32'(GAP_CYCLES - 1)) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maple_txn_scheduler.sv
// tb/tb_maple_txn_scheduler.sv - directed and randomized checks of the transaction scheduler
module tb_maple_txn_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int TOUT    = 50;
  localparam int GAP     = 16;
  localparam int DEPTH   = 64;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        busy;
  logic [15:0] timeout_count;

  maple_txn_scheduler_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  maple_txn_scheduler #(
    .NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT_CYCLES(TOUT), .GAP_CYCLES(GAP)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  logic [8:0]  req_mem [NUM_REQ][DEPTH];
  int          rd_ptr [NUM_REQ];
  int          wr_ptr [NUM_REQ];
  int          desc_len_q[$];
  int          desc_dly_q[$];
  logic [7:0]  desc_byte_q[$];
  logic [8:0]  rx_q[$];
  logic [11:0] exp_q[$];
  int          grant_log[$];
  int          exp_rr [6] = '{0, 2, 3, 0, 2, 3};
  int          last_g, cur_g, wait_k, rx_dly, gap_left, tx_stall, rsp_hs_cnt, tx_cnt;
  bit          in_frame, waiting, first_seen, tout_exp, idle_chk, bp_en, stall_en;
  logic [15:0] exp_tout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] pending();
    logic [NUM_REQ-1:0] p;
    for (int i = 0; i < NUM_REQ; i++) p[i] = rd_ptr[i] < wr_ptr[i];
    return p;
  endfunction

  // Round-robin rule: first pending requester after the previous winner, wrapping around.
  function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++)
      if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [63:0] outs_word();
    return 64'({bus.req_tready, bus.m_axis_tx_tvalid, bus.m_axis_tx_tdata, bus.m_axis_tx_tlast,
                bus.s_axis_rx_tready, bus.rsp_tvalid, bus.rsp_tdata, bus.rsp_tlast,
                bus.rsp_tdest, bus.rsp_tuser, busy, timeout_count});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_REQ; i++) begin rd_ptr[i] = 0; wr_ptr[i] = 0; end
    desc_len_q.delete(); desc_dly_q.delete(); desc_byte_q.delete();
    rx_q.delete(); exp_q.delete(); grant_log.delete();
    last_g = NUM_REQ - 1; cur_g = 0; wait_k = 0; rx_dly = 0; gap_left = 0; tx_stall = 0;
    in_frame = 0; waiting = 0; first_seen = 0; tout_exp = 0; idle_chk = 0; exp_tout = 0;
  endtask

  task automatic drive_idle();
    bus.req_tvalid = '0; bus.req_tdata = '0; bus.req_tlast = '0;
    bus.m_axis_tx_tready = 1'b0;
    bus.s_axis_rx_tvalid = 1'b0; bus.s_axis_rx_tdata = 8'h00; bus.s_axis_rx_tlast = 1'b0;
    bus.rsp_tready = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    model_clear();
    drive_idle();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    check("reset_outputs", outs_word(), 64'd0);
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    req_mem[r][wr_ptr[r]] = {last, d};
    wr_ptr[r]++;
  endtask

  task automatic push_desc(input int len, input int dly, input logic [31:0] bytes);
    desc_len_q.push_back(len);
    desc_dly_q.push_back(dly);
    for (int j = 0; j < len; j++) desc_byte_q.push_back(bytes[31 - 8*j -: 8]);
  endtask

  task automatic start_response();
    int len, dly;
    logic [7:0] b;
    if (desc_len_q.size() > 0) begin
      len = desc_len_q.pop_front();
      dly = desc_dly_q.pop_front();
    end else begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
      dly = $urandom_range(1, 20);
    end
    waiting = 1; wait_k = 0; first_seen = 0; tout_exp = (len == 0); rx_dly = dly;
    if (len == 0) exp_q.push_back({1'b1, IDW'(cur_g), 1'b1, 8'hFF});
    for (int j = 0; j < len; j++) begin
      b = (desc_byte_q.size() > 0) ? desc_byte_q.pop_front() : 8'($urandom);
      rx_q.push_back({j == len - 1, b});
      exp_q.push_back({1'b0, IDW'(cur_g), j == len - 1, b});
    end
  endtask

  task automatic drive();
    bit has, stall;
    for (int i = 0; i < NUM_REQ; i++) begin
      has   = rd_ptr[i] < wr_ptr[i];
      stall = stall_en && in_frame && (i == cur_g) && ($urandom_range(0, 3) == 0);
      bus.req_tvalid[i]        = has && !stall;
      bus.req_tdata[8*i +: 8]  = has ? req_mem[i][rd_ptr[i]][7:0] : 8'h00;
      bus.req_tlast[i]         = has ? req_mem[i][rd_ptr[i]][8] : 1'b0;
    end
    if (tx_stall > 0) begin
      bus.m_axis_tx_tready = 1'b0;
      tx_stall--;
    end else bus.m_axis_tx_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.rsp_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (waiting) wait_k++;
    if (waiting && !tout_exp && wait_k >= rx_dly && rx_q.size() > 0) begin
      bus.s_axis_rx_tvalid = 1'b1;
      bus.s_axis_rx_tdata  = rx_q[0][7:0];
      bus.s_axis_rx_tlast  = rx_q[0][8];
    end else begin
      bus.s_axis_rx_tvalid = 1'b0;
      bus.s_axis_rx_tdata  = 8'h00;
      bus.s_axis_rx_tlast  = 1'b0;
    end
  endtask

  task automatic sample();
    int g;
    logic [11:0] e;
    check("timeout_count", timeout_count, exp_tout);
    if (gap_left > 0) begin
      check("gap_quiet", 64'({busy, bus.req_tready, bus.m_axis_tx_tvalid, bus.rsp_tvalid,
                              bus.s_axis_rx_tready}), 64'h80);
      gap_left--;
      if (gap_left == 0) idle_chk = 1;
    end else if (idle_chk) begin
      check("idle_after_gap", busy, 0);
      idle_chk = 0;
    end
    if (bus.m_axis_tx_tvalid && bus.m_axis_tx_tready) begin
      tx_cnt++;
      if (!in_frame) begin
        g = rr_pick(last_g, pending());
        check("grant_id", bus.rsp_tdest, 64'(g));
        grant_log.push_back(int'(bus.rsp_tdest));
        cur_g = (g < 0) ? 0 : g;
        last_g = cur_g;
        in_frame = 1;
      end
      check("req_tready_onehot", bus.req_tready, 64'(1 << cur_g));
      if (rd_ptr[cur_g] < wr_ptr[cur_g]) begin
        check("tx_beat", {bus.m_axis_tx_tlast, bus.m_axis_tx_tdata}, req_mem[cur_g][rd_ptr[cur_g]]);
        rd_ptr[cur_g]++;
      end else check("tx_beat_present", rd_ptr[cur_g] < wr_ptr[cur_g], 1);
      if (bus.m_axis_tx_tlast) begin
        in_frame = 0;
        start_response();
      end
    end
    if (bus.s_axis_rx_tvalid) begin
      check("rx_ready_mirror", bus.s_axis_rx_tready, bus.rsp_tready);
      check("rsp_valid_mirror", bus.rsp_tvalid, 1);
    end
    if (bus.s_axis_rx_tvalid && bus.s_axis_rx_tready && rx_q.size() > 0) void'(rx_q.pop_front());
    if (waiting && bus.rsp_tvalid && !first_seen) begin
      first_seen = 1;
      check("rsp_latency", wait_k, tout_exp ? TOUT + 1 : rx_dly);
    end
    if (bus.rsp_tvalid && bus.rsp_tready) begin
      rsp_hs_cnt++;
      check("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_beat", {bus.rsp_tuser, bus.rsp_tdest, bus.rsp_tlast, bus.rsp_tdata}, e);
        if (e[11]) exp_tout++;
        if (e[8]) begin
          waiting = 0;
          gap_left = GAP;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1 drive();
    @(negedge ACLK);
    sample();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (n < budget && (pending() != 0 || in_frame || waiting || gap_left > 0 || idle_chk)) begin
      step();
      n++;
    end
    check("run_within_budget", n < budget, 1);
  endtask

  initial begin
    int n, total;
    bp_en = 0; stall_en = 0; rsp_hs_cnt = 0; tx_cnt = 0;
    model_clear();
    drive_idle();

    // Single command from requester 1
    do_reset();
    push_byte(1, 8'h01, 0); push_byte(1, 8'h20, 0); push_byte(1, 8'h00, 1);
    push_desc(2, 3, 32'h0500_0000);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_ready", bus.req_tready, 0);
    step();
    check("t1_send_busy", busy, 1);
    check("t1_send_ready", bus.req_tready, 4'b0010);
    run(2000);
    check("t1_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t1_grant_id", grant_log[0], 1);

    // Round robin among 0, 2 and 3
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      push_byte(0, 8'($urandom), 1); push_byte(2, 8'($urandom), 1); push_byte(3, 8'($urandom), 1);
      for (int k = 0; k < 3; k++) push_desc(1, 1, $urandom);
    end
    run(2000);
    check("rr_grants", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("rr_order", grant_log[i], exp_rr[i]);

    // Timeout on requester 2, then requester 3 served after the gap
    do_reset();
    push_byte(2, 8'hAA, 0); push_byte(2, 8'hBB, 1); push_desc(0, 0, 32'h0);
    push_byte(3, 8'hC3, 1); push_desc(1, 2, 32'h7E00_0000);
    run(2000);
    check("tout_count", timeout_count, 1);
    check("tout_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) check("tout_next_grant", grant_log[1], 3);

    // Response rises exactly on the terminal timer cycle
    push_byte(0, 8'h5A, 1); push_desc(2, TOUT, 32'h1234_0000);
    run(2000);
    check("race_tout_count", timeout_count, 1);

    // Randomized traffic with backpressure and a 10-cycle TX stall
    bp_en = 1; stall_en = 1; tx_stall = 10; tx_cnt = 0; total = 0;
    for (int f = 0; f < 16; f++) begin
      n = $urandom_range(0, NUM_REQ - 1);
      for (int b = 0, len = int'($urandom_range(1, 4)); b < len; b++) begin
        push_byte(n, 8'($urandom), b == len - 1);
        total++;
      end
    end
    run(30000);
    check("rand_tx_bytes", tx_cnt, total);
    check("rand_rsp_drained", exp_q.size(), 0);
    bp_en = 0; stall_en = 0;

    // Reset in RECV after 2 of 4 response bytes
    do_reset();
    push_byte(3, 8'h40, 1); push_desc(4, 2, 32'hA1A2_A3A4);
    rsp_hs_cnt = 0; n = 0;
    while (rsp_hs_cnt < 2 && n < 500) begin step(); n++; end
    check("mid_reset_reached", rsp_hs_cnt, 2);
    @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("mid_reset_outputs", outs_word(), 64'd0);
    model_clear();
    drive_idle();
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    push_byte(0, 8'h01, 1); push_byte(3, 8'h02, 1);
    push_desc(1, 1, 32'h3300_0000); push_desc(1, 1, 32'h4400_0000);
    run(2000);
    check("post_reset_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("post_reset_first", grant_log[0], 0);
      check("post_reset_second", grant_log[1], 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
